// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-unit bundle: decoder/pipeline side (master) and sequencer side (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             mem_branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             cnt_clr;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             exmem_write;
    logic             memwb_write;
    logic             ifid_flush;
    logic             exmem_flush;
    logic             idex_bubble;
    logic             pc_sel_branch;
    logic             mem_err;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
        output mem_branch_taken, dmem_req, dmem_ready, cnt_clr,
        input  pc_write, ifid_write, idex_write, exmem_write, memwb_write,
        input  ifid_flush, exmem_flush, idex_bubble, pc_sel_branch,
        input  mem_err, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
        input  mem_branch_taken, dmem_req, dmem_ready, cnt_clr,
        output pc_write, ifid_write, idex_write, exmem_write, memwb_write,
        output ifid_flush, exmem_flush, idex_bubble, pc_sel_branch,
        output mem_err, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch,
// data-memory waits with timeout trap, and saturating perf counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [TO_W-1:0]  wait_q, wait_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             lu, freeze, stall_inc;

    assign lu = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                ((bus.ex_rt == bus.id_rs) ||
                 (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

    assign freeze = (state_q == ERR) ||
                    (!bus.dmem_ready &&
                     ((state_q == MEM_WAIT) ||
                      ((state_q == RUN) && bus.dmem_req)));

    // Freeze outranks the branch so a pending redirect waits for memory.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.ifid_write    = 1'b0;
        bus.idex_write    = 1'b0;
        bus.exmem_write   = 1'b0;
        bus.memwb_write   = 1'b0;
        bus.ifid_flush    = 1'b0;
        bus.exmem_flush   = 1'b0;
        bus.idex_bubble   = 1'b0;
        bus.pc_sel_branch = 1'b0;
        if (rst_n && !freeze) begin
            bus.pc_write    = 1'b1;
            bus.ifid_write  = 1'b1;
            bus.idex_write  = 1'b1;
            bus.exmem_write = 1'b1;
            bus.memwb_write = 1'b1;
            if (bus.mem_branch_taken) begin
                bus.pc_sel_branch = 1'b1;
                bus.ifid_flush    = 1'b1;
                bus.idex_bubble   = 1'b1;
                bus.exmem_flush   = 1'b1;
            end else if (lu) begin
                bus.pc_write    = 1'b0;
                bus.ifid_write  = 1'b0;
                bus.idex_bubble = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            RUN: begin
                if (bus.dmem_req && !bus.dmem_ready) begin
                    state_d = MEM_WAIT;
                    wait_d  = TO_W'(1);
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_q == TO_W'(MEM_TIMEOUT)) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + TO_W'(1);
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign stall_inc = !bus.pc_write && (state_q != ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (bus.cnt_clr) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_inc && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if (bus.pc_sel_branch && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign bus.state     = state_q;
    assign bus.mem_err   = err_q;
    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed literal checks plus random
// stimulus compared every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int TO    = 4;
    localparam int CW    = 4;
    localparam int SAT   = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(TO),
        .TO_W(8),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // model state: mode 0 running, 1 waiting on memory, 2 trapped
    int m_mode  = 0;
    int m_wait  = 0;
    int m_err   = 0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // {pc_write, ifid_write, idex_write, exmem_write, memwb_write,
    //  ifid_flush, idex_bubble, exmem_flush, pc_sel_branch}
    function automatic logic [8:0] model_ctrl();
        bit hazard;
        bit busy;
        hazard = bus.ex_mem_read && bus.ex_rt != 0 &&
                 (bus.ex_rt == bus.id_rs ||
                  (bus.id_uses_rt && bus.ex_rt == bus.id_rt));
        busy = m_mode == 2 ||
               (!bus.dmem_ready && (m_mode == 1 || (m_mode == 0 && bus.dmem_req)));
        if (!rst_n || busy) return 9'b00000_0000;
        if (bus.mem_branch_taken) return 9'b11111_1111;
        if (hazard) return 9'b00111_0100;
        return 9'b11111_0000;
    endfunction

    function automatic logic [8:0] dut_ctrl();
        return {bus.pc_write, bus.ifid_write, bus.idex_write, bus.exmem_write,
                bus.memwb_write, bus.ifid_flush, bus.idex_bubble,
                bus.exmem_flush, bus.pc_sel_branch};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [8:0] c;
        if (!rst_n) begin
            m_mode  <= 0;
            m_wait  <= 0;
            m_err   <= 0;
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            c = model_ctrl();
            if (bus.cnt_clr) begin
                m_stall <= 0;
                m_flush <= 0;
            end else begin
                if (!c[8] && m_mode != 2) m_stall <= (m_stall < SAT) ? m_stall + 1 : SAT;
                if (c[0]) m_flush <= (m_flush < SAT) ? m_flush + 1 : SAT;
            end
            if (m_mode == 0 && bus.dmem_req && !bus.dmem_ready) begin
                m_mode <= 1;
                m_wait <= 1;
            end else if (m_mode == 1) begin
                if (bus.dmem_ready) begin
                    m_mode <= 0;
                    m_wait <= 0;
                end else if (m_wait == TO) begin
                    m_mode <= 2;
                    m_err  <= 1;
                end else begin
                    m_wait <= m_wait + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("ctrl", int'(dut_ctrl()), int'(model_ctrl()));
        chk("state", int'(bus.state), m_mode);
        chk("mem_err", int'(bus.mem_err), m_err);
        chk("stall_cnt", int'(bus.stall_cnt), m_stall);
        chk("flush_cnt", int'(bus.flush_cnt), m_flush);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_rs = 5'd0;
        bus.id_rt = 5'd0;
        bus.id_uses_rt = 1'b0;
        bus.ex_mem_read = 1'b0;
        bus.ex_rt = 5'd0;
        bus.mem_branch_taken = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.cnt_clr = 1'b0;
    endtask

    task automatic clr_cnt();
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
    endtask

    task automatic set_lu();
        bus.ex_mem_read = 1'b1;
        bus.ex_rt = 5'd8;
        bus.id_rs = 5'd8;
    endtask

    initial begin
        idle();
        #2;
        chk("rst_state", int'(bus.state), 0);
        chk("rst_pc_write", int'(bus.pc_write), 0);
        chk("rst_stall", int'(bus.stall_cnt), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // load-use inserts one bubble
        clr_cnt();
        set_lu();
        #1;
        chk("lu_pc_write", int'(bus.pc_write), 0);
        chk("lu_ifid_write", int'(bus.ifid_write), 0);
        chk("lu_bubble", int'(bus.idex_bubble), 1);
        tick();
        idle();
        bus.ex_mem_read = 1'b1;
        #1;
        chk("lu_stall_cnt", int'(bus.stall_cnt), 1);
        chk("r0_no_stall", int'(bus.pc_write), 1);
        tick();

        // branch overrides load-use
        idle();
        clr_cnt();
        set_lu();
        bus.mem_branch_taken = 1'b1;
        #1;
        chk("br_sel", int'(bus.pc_sel_branch), 1);
        chk("br_pc_write", int'(bus.pc_write), 1);
        chk("br_flushes", int'({bus.ifid_flush, bus.idex_bubble, bus.exmem_flush}), 7);
        tick();
        idle();
        #1;
        chk("br_flush_cnt", int'(bus.flush_cnt), 1);
        chk("br_stall_cnt", int'(bus.stall_cnt), 0);

        // three-cycle memory wait
        clr_cnt();
        bus.dmem_req = 1'b1;
        #1;
        chk("mw_freeze", int'(bus.pc_write), 0);
        tick();
        chk("mw_state", int'(bus.state), 1);
        tick();
        tick();
        bus.dmem_ready = 1'b1;
        #1;
        chk("mw_release", int'(bus.memwb_write), 1);
        tick();
        idle();
        #1;
        chk("mw_run", int'(bus.state), 0);
        chk("mw_stall_cnt", int'(bus.stall_cnt), 3);

        // ready on the last allowed wait cycle
        bus.dmem_req = 1'b1;
        repeat (4) tick();
        bus.dmem_ready = 1'b1;
        #1;
        chk("bd_waiting", int'(bus.state), 1);
        tick();
        idle();
        #1;
        chk("bd_run", int'(bus.state), 0);
        chk("bd_no_err", int'(bus.mem_err), 0);

        // stall counter saturation and clear priority
        clr_cnt();
        set_lu();
        repeat (20) tick();
        chk("sat_hold", int'(bus.stall_cnt), 15);
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        #1;
        chk("clr_prio", int'(bus.stall_cnt), 0);
        tick();
        chk("after_clr", int'(bus.stall_cnt), 1);
        idle();

        // timeout trap
        bus.dmem_req = 1'b1;
        repeat (4) tick();
        chk("to_c4_state", int'(bus.state), 1);
        chk("to_c4_err", int'(bus.mem_err), 0);
        tick();
        chk("to_c5_state", int'(bus.state), 2);
        chk("to_c5_err", int'(bus.mem_err), 1);
        bus.dmem_req = 1'b0;
        bus.dmem_ready = 1'b1;
        bus.mem_branch_taken = 1'b1;
        tick();
        tick();
        chk("to_absorb", int'(bus.state), 2);
        chk("to_frozen", int'(bus.pc_sel_branch), 0);
        rst_n = 1'b0;
        #1;
        chk("to_rst_state", int'(bus.state), 0);
        chk("to_rst_err", int'(bus.mem_err), 0);
        chk("to_rst_out", int'(bus.pc_write), 0);
        idle();
        tick();
        rst_n = 1'b1;
        tick();

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.id_rs = 5'($urandom_range(0, 3));
            bus.id_rt = 5'($urandom_range(0, 3));
            bus.ex_rt = 5'($urandom_range(0, 3));
            bus.id_uses_rt = 1'($urandom_range(0, 1));
            bus.ex_mem_read = 1'($urandom_range(0, 1));
            bus.mem_branch_taken = ($urandom_range(0, 99) < 20);
            bus.dmem_req = ($urandom_range(0, 99) < 30);
            bus.dmem_ready = ($urandom_range(0, 99) < 45);
            bus.cnt_clr = ($urandom_range(0, 99) < 3);
            rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            tick();
        end
        rst_n = 1'b1;
        idle();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It sits beside the opcode decoder and drives the write-enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three events: load-use hazards, taken branches resolved in MEM, and multi-cycle data-memory waits. It also times out hung memory accesses and keeps saturating stall/flush performance counters.

## Interface
- MEM_TIMEOUT, 255: max wait-cycle count before the error trap; range 1..2^TO_W-1.
- TO_W, 8: wait counter width.
- CNT_W, 16: performance counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt (R-type, beq/bne, sw).
- ex_mem_read  in  1  the EX-stage instruction is a load (ID/EX M read bit).
- ex_rt  in  5  destination rt of the EX-stage load.
- mem_branch_taken  in  1  branch in MEM is taken.
- dmem_req  in  1  MEM stage is accessing data memory this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- cnt_clr  in  1  synchronous clear of the performance counters.
- pc_write, ifid_write, idex_write, exmem_write, memwb_write  out  1 each  register load enables.
- ifid_flush, exmem_flush  out  1 each  load a NOP/zero-control into the register.
- idex_bubble  out  1  zero the wb/M/Ex control fields loaded into ID/EX.
- pc_sel_branch  out  1  PC loads the branch target.
- mem_err  out  1  sticky timeout error.
- state  out  2  RUN=0, MEM_WAIT=1, ERR=2.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

## Operation
- Define lu = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- Define freeze = (state == MEM_WAIT & !dmem_ready) | (state == RUN & dmem_req & !dmem_ready) | state == ERR.
- All control outputs are combinational (Mealy) from state and inputs. Evaluate in this priority order:
  1. freeze: every write enable is 0; every flush, idex_bubble and pc_sel_branch is 0. The whole pipeline holds, including a pending branch.
  2. mem_branch_taken: pc_write=1, pc_sel_branch=1, ifid_flush=1, idex_bubble=1, exmem_flush=1, and all write enables are 1. The branch overrides lu.
  3. lu: pc_write=0, ifid_write=0, idex_bubble=1. The other enables are 1. This inserts exactly one bubble per occurrence.
  4. Otherwise, all write enables are 1 and all flushes are 0.
- State transitions:
  - RUN -> MEM_WAIT on dmem_req & !dmem_ready; wait_cnt <= 1.
  - MEM_WAIT with dmem_ready -> RUN. In this cycle, priorities 2-4 apply as in RUN. wait_cnt <= 0.
  - MEM_WAIT with !dmem_ready and wait_cnt == MEM_TIMEOUT -> ERR; mem_err <= 1.
  - MEM_WAIT with !dmem_ready otherwise: wait_cnt++.
  - ERR is absorbing until rst_n is asserted.
- Counters:
  - stall_cnt += 1 on each cycle with pc_write == 0 and state != ERR.
  - flush_cnt += 1 on each cycle with pc_sel_branch == 1.
  - Both saturate at all-ones.
  - cnt_clr has priority over increment; the counter reads 0 on the next cycle.

## Timing
- Reset (rst_n low): state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0. While rst_n is low, every write enable, flush, idex_bubble and pc_sel_branch is forced to 0.
- Hazard and branch controls have zero latency: they are valid in the same cycle as their inputs.
- A memory stall releases in the cycle dmem_ready is high; the pipeline advances at that cycle's clock edge.
- Timeout: a request entering at cycle c with ready never asserted gives state=ERR and mem_err=1 from cycle c+MEM_TIMEOUT+1.
- dmem_ready on the same cycle wait_cnt == MEM_TIMEOUT: ready wins and the block returns to RUN with no error.
- Asynchronous reset mid-MEM_WAIT or in ERR returns the block to RUN immediately. Counters and mem_err clear.
- Branch, lu and memory wait in the same RUN cycle: freeze only. Branch handling follows in the release cycle.

## Test plan
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 -> for exactly one cycle pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt=1 afterwards. With ex_rt=0 there is no stall.
- Branch: mem_branch_taken=1 with lu also true -> pc_sel_branch=1, ifid_flush=1, idex_bubble=1, exmem_flush=1, pc_write=1; flush_cnt increments by 1.
- Memory wait: dmem_req=1 with dmem_ready low for 3 cycles, then high -> write enables 0 for 3 cycles, state=MEM_WAIT, then RUN; stall_cnt=3.
- Timeout (MEM_TIMEOUT=4): request with no ready -> mem_err=1 and state=ERR at cycle c+5 and stay there. Asserting rst_n low clears everything.
- Boundary: ready arrives exactly on the cycle wait_cnt=4 -> no error, state returns to RUN.
- Counters: preload stall_cnt near saturation (CNT_W=4, 20 stalls) -> counter holds at 15. cnt_clr together with a stall -> 0 next cycle.
